nand_seq_alu: RTL and testbench
===============================

Name: nand_seq_alu

Overview:
- Multi-cycle bitwise logic unit built on exactly one shared W-bit NAND stage (y_i = ~(x_i & z_i)).
- An FSM steers the NAND stage's two operand muxes and its destination register over 1–5 passes to realise NOT, AND, OR, NOR, XOR and XNOR.
- Sits as the sequencing controller in front of the team's NAND-universal gate datapath.
- Uses a start/busy/done handshake.

Parameters:
- W, 4, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  function select (encoding below)
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- y  output  W  registered result; held until the next result write
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; y is valid while done is high
- nand_ops  output  8  running count of NAND passes since reset; saturates at 255

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; y=0, busy=0, done=0, nand_ops=0.
  - Internal A, B, op, step and t1..t3 registers all cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a→A, b→B, op; step=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each cycle performs one NAND pass per the table below; step increments.
  - Each pass increments nand_ops (saturating).
  - On the final pass edge: write the NAND output to y; go to DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: done is high in the cycle immediately after edge E0+n, where E0 is the start-sampling edge and n is the op's pass count. An op with n passes therefore occupies busy for n+1 cycles.
- start while busy (RUN or DONE) is ignored; it is not queued.
- A new start can be accepted on the first IDLE cycle after DONE, so back-to-back throughput is n+2 cycles per op.
- The a and b inputs may change freely after the start edge; results use the latched values only.
- Pass sequences (s = step; dst ← nand(x,z)); op values outside those listed do not exist (3-bit, all used):
  - op=0 NOT_A (n=1): s0 y←(A,A)
  - op=1 NOT_B (n=1): s0 y←(B,B)
  - op=2 NAND (n=1): s0 y←(A,B)
  - op=3 AND (n=2): s0 t1←(A,B); s1 y←(t1,t1)
  - op=4 OR (n=3): s0 t1←(A,A); s1 t2←(B,B); s2 y←(t1,t2)
  - op=5 NOR (n=4): s0 t1←(A,A); s1 t2←(B,B); s2 t3←(t1,t2); s3 y←(t3,t3)
  - op=6 XOR (n=4): s0 t1←(A,B); s1 t2←(A,t1); s2 t3←(B,t1); s3 y←(t2,t3)
  - op=7 XNOR (n=5): XOR s0–s2 as above; s3 t1←(t2,t3); s4 y←(t1,t1)
- Only one NAND instance exists. No other bitwise logic operator may be used on the datapath; mux selects are the exception.
- y changes only on a final-pass edge or on reset.

Test Plan:
- Reset, then W=4, a=1100, b=1010, run each op in turn → y = NOT_A 0011, NOT_B 0101, NAND 0111, AND 1000, OR 1110, NOR 0001, XOR 0110, XNOR 1001. Each done arrives n edges after start (1,1,1,2,3,4,4,5). Final nand_ops=21.
- XNOR with a=0000, b=1111 → busy high 6 cycles, done single-cycle, y=0000. Change a/b mid-operation → result unaffected.
- AND with a=1111, b=0110; pulse start again during RUN and during DONE → only one done, y=0110, nand_ops increases by exactly 2.
- XOR with a=1010, b=0110 → y=1100. Assert rst_n=0 after 2 RUN cycles → y=0, busy=0, done=0, nand_ops=0 immediately (asynchronous); no done after release. Then start OR a=0001, b=0010 → y=0011 after 3 passes.
- Back-to-back: start held high continuously with op=2, a=1111, b=1111 → new operation accepted every 3 cycles, y=0000 each time. Run past 255 total passes → nand_ops holds at 255.

Source files
------------

// File: rtl/nand_seq_alu.sv
//------------------------------------------------------------------------------
// nand_seq_alu : multi-cycle bitwise logic unit sequencing one shared NAND stage
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nand_seq_alu #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [7:0]   nand_ops
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_A  = 3'd0,
    SRC_B  = 3'd1,
    SRC_T1 = 3'd2,
    SRC_T2 = 3'd3,
    SRC_T3 = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    DST_Y  = 2'd0,
    DST_T1 = 2'd1,
    DST_T2 = 2'd2,
    DST_T3 = 2'd3
  } dst_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic [2:0]   step_q, step_d;
  logic [W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [W-1:0] y_q, y_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   nand_ops_q, nand_ops_d;

  src_t         x_sel, z_sel;
  dst_t         dst_sel;
  logic         last_pass;
  logic [W-1:0] x_op, z_op, nand_out;

  // Pass table: operand sources, destination and final-pass flag per (op, step).
  always_comb begin
    x_sel     = SRC_A;
    z_sel     = SRC_A;
    dst_sel   = DST_Y;
    last_pass = 1'b1;
    case (op_q)
      3'd0: begin x_sel = SRC_A; z_sel = SRC_A; end
      3'd1: begin x_sel = SRC_B; z_sel = SRC_B; end
      3'd2: begin x_sel = SRC_A; z_sel = SRC_B; end
      3'd3: begin
        case (step_q)
          3'd0: begin x_sel = SRC_A; z_sel = SRC_B; dst_sel = DST_T1; last_pass = 1'b0; end
          default: begin x_sel = SRC_T1; z_sel = SRC_T1; end
        endcase
      end
      3'd4: begin
        case (step_q)
          3'd0: begin x_sel = SRC_A; z_sel = SRC_A; dst_sel = DST_T1; last_pass = 1'b0; end
          3'd1: begin x_sel = SRC_B; z_sel = SRC_B; dst_sel = DST_T2; last_pass = 1'b0; end
          default: begin x_sel = SRC_T1; z_sel = SRC_T2; end
        endcase
      end
      3'd5: begin
        case (step_q)
          3'd0: begin x_sel = SRC_A;  z_sel = SRC_A;  dst_sel = DST_T1; last_pass = 1'b0; end
          3'd1: begin x_sel = SRC_B;  z_sel = SRC_B;  dst_sel = DST_T2; last_pass = 1'b0; end
          3'd2: begin x_sel = SRC_T1; z_sel = SRC_T2; dst_sel = DST_T3; last_pass = 1'b0; end
          default: begin x_sel = SRC_T3; z_sel = SRC_T3; end
        endcase
      end
      3'd6: begin
        case (step_q)
          3'd0: begin x_sel = SRC_A; z_sel = SRC_B;  dst_sel = DST_T1; last_pass = 1'b0; end
          3'd1: begin x_sel = SRC_A; z_sel = SRC_T1; dst_sel = DST_T2; last_pass = 1'b0; end
          3'd2: begin x_sel = SRC_B; z_sel = SRC_T1; dst_sel = DST_T3; last_pass = 1'b0; end
          default: begin x_sel = SRC_T2; z_sel = SRC_T3; end
        endcase
      end
      default: begin
        case (step_q)
          3'd0: begin x_sel = SRC_A;  z_sel = SRC_B;  dst_sel = DST_T1; last_pass = 1'b0; end
          3'd1: begin x_sel = SRC_A;  z_sel = SRC_T1; dst_sel = DST_T2; last_pass = 1'b0; end
          3'd2: begin x_sel = SRC_B;  z_sel = SRC_T1; dst_sel = DST_T3; last_pass = 1'b0; end
          3'd3: begin x_sel = SRC_T2; z_sel = SRC_T3; dst_sel = DST_T1; last_pass = 1'b0; end
          default: begin x_sel = SRC_T1; z_sel = SRC_T1; end
        endcase
      end
    endcase
  end

  always_comb begin
    case (x_sel)
      SRC_A:   x_op = a_q;
      SRC_B:   x_op = b_q;
      SRC_T1:  x_op = t1_q;
      SRC_T2:  x_op = t2_q;
      default: x_op = t3_q;
    endcase
    case (z_sel)
      SRC_A:   z_op = a_q;
      SRC_B:   z_op = b_q;
      SRC_T1:  z_op = t1_q;
      SRC_T2:  z_op = t2_q;
      default: z_op = t3_q;
    endcase
  end

  // The one and only NAND stage of the unit.
  assign nand_out = ~(x_op & z_op);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    step_d     = step_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    t3_d       = t3_q;
    y_d        = y_q;
    done_d     = 1'b0;
    nand_ops_d = nand_ops_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          step_d  = 3'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_d = step_q + 3'd1;
        if (nand_ops_q != 8'hFF) begin
          nand_ops_d = nand_ops_q + 8'd1;
        end
        case (dst_sel)
          DST_T1:  t1_d = nand_out;
          DST_T2:  t2_d = nand_out;
          DST_T3:  t3_d = nand_out;
          default: y_d  = nand_out;
        endcase
        if (last_pass) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'd0;
      step_q     <= 3'd0;
      t1_q       <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nand_ops_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      step_q     <= step_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nand_ops_q <= nand_ops_d;
    end
  end

  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nand_ops = nand_ops_q;

endmodule

`default_nettype wire

// File: tb/tb_nand_seq_alu.sv
//------------------------------------------------------------------------------
// tb_nand_seq_alu : directed scoreboard bench for nand_seq_alu
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_nand_seq_alu;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b, y;
  logic         busy, done;
  logic [7:0]   nand_ops;

  always #5 clk = ~clk;

  nand_seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .y(y), .busy(busy), .done(done), .nand_ops(nand_ops)
  );

  typedef struct {
    logic [3:0] y;
    int         n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_ops = 0;

  function automatic logic [3:0] model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    case (o)
      3'd0:    return ~x;
      3'd1:    return ~z;
      3'd2:    return ~(x & z);
      3'd3:    return x & z;
      3'd4:    return x | z;
      3'd5:    return ~(x | z);
      3'd6:    return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  function automatic int passes(input logic [2:0] o);
    case (o)
      3'd0, 3'd1, 3'd2: return 1;
      3'd3:             return 2;
      3'd4:             return 3;
      3'd5, 3'd6:       return 4;
      default:          return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_ops(input int n);
    exp_ops = (exp_ops + n > 255) ? 255 : exp_ops + n;
  endtask

  // Launch one op, follow it until IDLE, then score latency, busy span, done count, y.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] av,
                        input logic [3:0] bv, input bit scramble, input bit pulse);
    exp_t e;
    int   bc, dc, lat;
    bit   timeout;
    e.y = model(o, av, bv);
    e.n = passes(o);
    sb.push_back(e);
    op = o; a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    bc = 0; dc = 0; lat = -1; timeout = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      bc++;
      if (done) begin
        dc++;
        lat = k;
      end
      if (scramble) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      if (pulse) start = 1'b1;
      step();
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    e = sb.pop_front();
    add_ops(e.n);
    chk({tag, "_latency"}, lat, e.n);
    chk({tag, "_busy_cycles"}, bc, e.n + 1);
    chk({tag, "_done_count"}, dc, 1);
    chk({tag, "_y"}, 32'(y), 32'(e.y));
    chk({tag, "_nand_ops"}, 32'(nand_ops), exp_ops);
  endtask

  initial begin
    exp_t e;
    int   dn, dones, last_done;
    bit   pb;

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nand_ops", 32'(nand_ops), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("op%0d", i), 3'(i), 4'b1100, 4'b1010, 1'b0, 1'b0);
    end
    chk("ops_after_sweep", 32'(nand_ops), 32'd21);

    run_op("xnor_scramble", 3'd7, 4'b0000, 4'b1111, 1'b1, 1'b0);
    run_op("and_pulse", 3'd3, 4'b1111, 4'b0110, 1'b0, 1'b1);

    // XOR aborted by reset after two passes
    op = 3'd6; a = 4'b1010; b = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    exp_ops = 0;
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_nand_ops", 32'(nand_ops), 32'd0);
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_op("or_after_abort", 3'd4, 4'b0001, 4'b0010, 1'b0, 1'b0);

    // Back-to-back NANDs with start held high, run past counter saturation
    op = 3'd2; a = 4'b1111; b = 4'b1111; start = 1'b1;
    dones = 0; last_done = -1; pb = 1'b0;
    for (int cyc = 0; cyc < 1200 && dones < 260; cyc++) begin
      step();
      if (busy && !pb) begin
        e.y = model(3'd2, 4'b1111, 4'b1111);
        e.n = 1;
        sb.push_back(e);
      end
      pb = busy;
      if (done) begin
        if (sb.size() == 0) begin
          chk("b2b_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          add_ops(e.n);
          chk("b2b_y", 32'(y), 32'(e.y));
        end
        if (last_done >= 0) chk("b2b_period", cyc - last_done, 3);
        last_done = cyc;
        dones++;
        if (dones == 260) start = 1'b0;
      end
    end
    start = 1'b0;
    step();
    step();
    chk("b2b_done_total", dones, 260);
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_queue_empty", sb.size(), 0);
    chk("b2b_nand_ops_model", 32'(nand_ops), exp_ops);
    chk("b2b_nand_ops_sat", 32'(nand_ops), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
